// File: rtl/clock_pkg.sv
// Shared mode encoding and BCD digit-pair limits for the HH:MM:SS clock.
// Constants only: no logic and no latency.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_MIN  = 2'd1,
    MODE_SET_HOUR = 2'd2
  } mode_e;

  localparam logic [3:0] SEC_MAX_TENS = 4'd5;
  localparam logic [3:0] SEC_MAX_ONES = 4'd9;
  localparam logic [3:0] MIN_MAX_TENS = 4'd5;
  localparam logic [3:0] MIN_MAX_ONES = 4'd9;
  localparam logic [3:0] HR_MAX_TENS  = 4'd2;
  localparam logic [3:0] HR_MAX_ONES  = 4'd3;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that wraps to 00 after {max_tens,max_ones}; clr wins over inc.
// The new value is visible one cycle after inc; wrap is combinational, for cascading.
module bcd2_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  input  logic [3:0] max_tens,
  input  logic [3:0] max_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       wrap
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  assign wrap = inc && (tens_q == max_tens) && (ones_q == max_ones);
  assign tens = tens_q;
  assign ones = ones_q;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (inc) begin
      if (wrap) begin
        tens_d = 4'd0;
        ones_d = 4'd0;
      end else if (ones_q == 4'd9) begin
        tens_d = tens_q + 4'd1;
        ones_d = 4'd0;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// 24-hour clock controller: 1 Hz prescaler, debounced mode/inc buttons, RUN/SET_MIN/SET_HOUR FSM.
// A button press takes effect DEBOUNCE_CYCLES+3 cycles after its raw edge; a tick updates the digits one cycle later.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV        = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] mode,
  output logic       tick_1hz,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  localparam int              PW         = $clog2(TICK_DIV);
  localparam int              DW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]   DEB_MAX    = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]   DEB_ARM    = DW'(DEBOUNCE_CYCLES - 1);

  logic          mode_s1_q, mode_s2_q, mode_press_q, mode_press_d;
  logic          inc_s1_q, inc_s2_q, inc_press_q, inc_press_d;
  logic [DW-1:0] mode_cnt_q, mode_cnt_d;
  logic [DW-1:0] inc_cnt_q, inc_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  mode_e         mode_q, mode_d;

  logic run, tick, inc_ok;
  logic sec_wrap, min_wrap, hr_wrap;
  logic sec_inc, sec_clr, min_inc, hr_inc;

  // The press pulse fires on the edge where the saturating count reaches its limit.
  always_comb begin
    mode_cnt_d   = '0;
    mode_press_d = 1'b0;
    if (mode_s2_q) begin
      mode_cnt_d   = (mode_cnt_q == DEB_MAX) ? DEB_MAX : mode_cnt_q + 1'b1;
      mode_press_d = (mode_cnt_q == DEB_ARM);
    end
  end

  always_comb begin
    inc_cnt_d   = '0;
    inc_press_d = 1'b0;
    if (inc_s2_q) begin
      inc_cnt_d   = (inc_cnt_q == DEB_MAX) ? DEB_MAX : inc_cnt_q + 1'b1;
      inc_press_d = (inc_cnt_q == DEB_ARM);
    end
  end

  assign run    = (mode_q == MODE_RUN);
  assign tick   = run && (presc_q == PRESC_LAST);
  assign inc_ok = inc_press_q && !mode_press_q;

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN:      if (mode_press_q) mode_d = MODE_SET_MIN;
      MODE_SET_MIN:  if (mode_press_q) mode_d = MODE_SET_HOUR;
      MODE_SET_HOUR: if (mode_press_q) mode_d = MODE_RUN;
      default:       mode_d = MODE_RUN;
    endcase
  end

  // Held at zero outside RUN and on the leaving edge, so re-entry always starts a full period.
  always_comb begin
    presc_d = '0;
    if (run && (mode_d == MODE_RUN) && (presc_q != PRESC_LAST))
      presc_d = presc_q + 1'b1;
  end

  assign sec_inc = tick;
  assign sec_clr = run && mode_press_q;
  assign min_inc = (run && sec_wrap) || ((mode_q == MODE_SET_MIN) && inc_ok);
  assign hr_inc  = (run && min_wrap) || ((mode_q == MODE_SET_HOUR) && inc_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_s1_q    <= 1'b0;
      mode_s2_q    <= 1'b0;
      mode_cnt_q   <= '0;
      mode_press_q <= 1'b0;
      inc_s1_q     <= 1'b0;
      inc_s2_q     <= 1'b0;
      inc_cnt_q    <= '0;
      inc_press_q  <= 1'b0;
      presc_q      <= '0;
      mode_q       <= MODE_RUN;
    end else begin
      mode_s1_q    <= btn_mode;
      mode_s2_q    <= mode_s1_q;
      mode_cnt_q   <= mode_cnt_d;
      mode_press_q <= mode_press_d;
      inc_s1_q     <= btn_inc;
      inc_s2_q     <= inc_s1_q;
      inc_cnt_q    <= inc_cnt_d;
      inc_press_q  <= inc_press_d;
      presc_q      <= presc_d;
      mode_q       <= mode_d;
    end
  end

  bcd2_counter u_sec (
    .clk(clk), .reset(reset), .inc(sec_inc), .clr(sec_clr),
    .max_tens(SEC_MAX_TENS), .max_ones(SEC_MAX_ONES),
    .tens(sec_tens), .ones(sec_ones), .wrap(sec_wrap)
  );

  bcd2_counter u_min (
    .clk(clk), .reset(reset), .inc(min_inc), .clr(1'b0),
    .max_tens(MIN_MAX_TENS), .max_ones(MIN_MAX_ONES),
    .tens(min_tens), .ones(min_ones), .wrap(min_wrap)
  );

  // Hours wrap is unused: the day rolls over with no further carry.
  bcd2_counter u_hr (
    .clk(clk), .reset(reset), .inc(hr_inc), .clr(1'b0),
    .max_tens(HR_MAX_TENS), .max_ones(HR_MAX_ONES),
    .tens(hr_tens), .ones(hr_ones), .wrap(hr_wrap)
  );

  assign mode     = mode_q;
  assign tick_1hz = tick;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scoreboard bench for clock_time_ctrl with TICK_DIV=10, DEBOUNCE_CYCLES=4.
module tb_clock_time_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [1:0] mode;
  logic       tick_1hz;
  logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic [23:0] now_tm;

  clock_time_ctrl #(.TICK_DIV(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .mode(mode), .tick_1hz(tick_1hz),
    .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones)
  );

  assign now_tm = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       nm;
    bit          ct;
    logic [23:0] tm;
    bit          cm;
    logic [1:0]  md;
    bit          ck;
    logic        tk;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_e;
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  bit  flush = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int c, string n, bit ct, logic [23:0] t,
                               bit cm, logic [1:0] m, bit ck, logic k);
    sb_t e;
    e.cyc = c; e.nm = n; e.ct = ct; e.tm = t; e.cm = cm; e.md = m; e.ck = ck; e.tk = k;
    sb_q.push_back(e);
  endfunction

  // Monitor: pops every expectation whose cycle has arrived and compares it to the DUT.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && (flush || sb_q[0].cyc <= cyc)) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (mon_e.cyc != cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now cycle %0d)",
                 mon_e.nm, mon_e.cyc, cyc);
      end else if ((mon_e.ct && now_tm !== mon_e.tm) || (mon_e.cm && mode !== mon_e.md) ||
                   (mon_e.ck && tick_1hz !== mon_e.tk)) begin
        failures++;
        $display("FAIL %s @%0d: got time=%h mode=%0d tick=%0b, want time=%h mode=%0d tick=%0b",
                 mon_e.nm, cyc, now_tm, mode, tick_1hz, mon_e.tm, mon_e.md, mon_e.tk);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw buttons held long enough for one clean press, then released long enough to re-arm.
  task automatic press(input bit m, input bit i);
    btn_mode = m;
    btn_inc  = i;
    step(7);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(3);
  endtask

  task automatic press_n(input bit m, input bit i, input int n);
    for (int k = 0; k < n; k++) press(m, i);
  endtask

  task automatic chk(input string n, input logic [23:0] t, input logic [1:0] m);
    push(cyc, n, 1'b1, t, 1'b1, m, 1'b0, 1'b0);
  endtask

  int n;

  initial begin
    step(2);
    reset = 1'b0;
    n = cyc;
    push(n, "reset", 1'b1, 24'h000000, 1'b1, 2'd0, 1'b1, 1'b0);
    for (int j = 1; j <= 600; j++)
      push(n + j, $sformatf("run_c%0d", j), (j == 590) || (j == 600),
           (j == 600) ? 24'h000100 : 24'h000059, 1'b1, 2'd0, 1'b1, (j % 10) == 9);
    step(600);

    press(1'b1, 1'b0);
    chk("enter_set_min", 24'h000100, 2'd1);

    btn_inc = 1'b1;
    step(3);
    btn_inc = 1'b0;
    step(10);
    chk("short_inc", 24'h000100, 2'd1);

    n = cyc;
    btn_inc = 1'b1;
    push(n + 6,   "inc_pre",  1'b1, 24'h000100, 1'b1, 2'd1, 1'b0, 1'b0);
    push(n + 7,   "inc_lat",  1'b1, 24'h000200, 1'b1, 2'd1, 1'b0, 1'b0);
    push(n + 100, "inc_once", 1'b1, 24'h000200, 1'b1, 2'd1, 1'b0, 1'b0);
    step(100);
    btn_inc = 1'b0;
    step(5);

    press_n(1'b0, 1'b1, 57);
    chk("min59", 24'h005900, 2'd1);
    press(1'b1, 1'b0);
    chk("set_hour", 24'h005900, 2'd2);
    press_n(1'b0, 1'b1, 23);
    chk("hr23", 24'h235900, 2'd2);
    press(1'b1, 1'b0);
    chk("run_2359", 24'h235900, 2'd0);
    n = cyc;
    push(n + 596, "pre_wrap", 1'b1, 24'h235959, 1'b1, 2'd0, 1'b1, 1'b1);
    push(n + 597, "day_wrap", 1'b1, 24'h000000, 1'b1, 2'd0, 1'b1, 1'b0);
    step(597);

    press(1'b1, 1'b0);
    press_n(1'b0, 1'b1, 59);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("run_0059", 24'h005900, 2'd0);
    n = cyc;
    push(n + 366, "tick_36",  1'b1, 24'h005936, 1'b1, 2'd0, 1'b1, 1'b1);
    push(n + 368, "at_5937",  1'b1, 24'h005937, 1'b1, 2'd0, 1'b1, 1'b0);
    step(368);
    press(1'b1, 1'b0);
    chk("sec_clear", 24'h005900, 2'd1);
    press(1'b0, 1'b1);
    chk("no_hr_carry", 24'h000000, 2'd1);
    press(1'b1, 1'b0);
    chk("s4_set_hour", 24'h000000, 2'd2);
    press_n(1'b0, 1'b1, 23);
    chk("hr_23", 24'h230000, 2'd2);
    press(1'b0, 1'b1);
    chk("hr_wrap", 24'h000000, 2'd2);
    press(1'b0, 1'b1);
    chk("hr_01", 24'h010000, 2'd2);

    n = cyc;
    push(n + 6,  "both_sh_pre", 1'b1, 24'h010000, 1'b1, 2'd2, 1'b1, 1'b0);
    push(n + 7,  "both_sh",     1'b1, 24'h010000, 1'b1, 2'd0, 1'b1, 1'b0);
    push(n + 15, "no_early",    1'b1, 24'h010000, 1'b1, 2'd0, 1'b1, 1'b0);
    push(n + 16, "first_tick",  1'b1, 24'h010000, 1'b1, 2'd0, 1'b1, 1'b1);
    push(n + 17, "first_sec",   1'b1, 24'h010001, 1'b1, 2'd0, 1'b1, 1'b0);
    press(1'b1, 1'b1);
    step(7);
    n = cyc;
    push(n + 6, "both_run_pre", 1'b1, 24'h010001, 1'b1, 2'd0, 1'b0, 1'b0);
    push(n + 7, "both_run",     1'b1, 24'h010000, 1'b1, 2'd1, 1'b1, 1'b0);
    press(1'b1, 1'b1);

    press_n(1'b0, 1'b1, 22);
    press(1'b1, 1'b0);
    press_n(1'b0, 1'b1, 13);
    chk("at_1422", 24'h142200, 2'd2);
    btn_inc = 1'b1;
    step(3);
    btn_inc = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n = cyc;
    push(n,      "mid_reset",  1'b1, 24'h000000, 1'b1, 2'd0, 1'b1, 1'b0);
    push(n + 9,  "rst_tick",   1'b1, 24'h000000, 1'b1, 2'd0, 1'b1, 1'b1);
    push(n + 10, "rst_sec",    1'b1, 24'h000001, 1'b1, 2'd0, 1'b1, 1'b0);
    step(10);

    for (int i = 0; i < 3000 && sb_q.size() > 0; i++) @(posedge clk);
    flush = 1'b1;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
Controller for a 24-hour HH:MM:SS digital clock built from two-digit BCD counters.
- Divides the system clock to a 1 Hz tick and cascades seconds into minutes into hours.
- Debounces two push-buttons and runs a mode FSM (RUN / SET_MIN / SET_HOUR) so the user can set the time.
- Sits between the board buttons and the seven-segment display driver.
- Owns and sequences three instances of a synchronous BCD digit-pair counter.

Parameters:
- TICK_DIV, 100_000_000, system-clock cycles per 1 Hz tick (must be >= 2).
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable-high synchronised cycles required to accept a press (must be >= 1).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_mode  in  1  raw, asynchronous, bouncy mode button.
- btn_inc  in  1  raw, asynchronous, bouncy increment button.
- mode  out  2  current mode: 0 = RUN, 1 = SET_MIN, 2 = SET_HOUR.
- tick_1hz  out  1  one-cycle pulse on each prescaler terminal count.
- hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD time digits.

Behaviour:
- Reset (sampled on a clk edge with reset = 1) clears everything to the listed values; reset overrides all other activity, including mid-debounce and mid-set.
  - All digits 0 (00:00:00).
  - mode = RUN, tick_1hz = 0, prescaler = 0.
  - Synchronisers and debounce counters = 0; press latches cleared.
- Button path, per button:
  - 2-FF synchroniser, then debounce counter.
  - While the synchronised level is 1, the counter increments, saturating at DEBOUNCE_CYCLES; a level of 0 clears it.
  - A one-cycle press pulse fires on the cycle the counter first reaches DEBOUNCE_CYCLES.
  - A held button produces exactly one pulse; a new pulse requires at least one synchronised low cycle.
  - Latency from a clean raw rising edge to the press pulse is DEBOUNCE_CYCLES + 2 cycles.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - tick_1hz = 1 in the cycle the prescaler equals TICK_DIV-1; the prescaler wraps to 0 on the next edge.
  - Outside RUN the prescaler is held at 0 and tick_1hz is 0.
- RUN mode:
  - On a tick, seconds increment on the same edge the tick is sampled; the digits are visible the cycle after tick_1hz.
  - Seconds wrap 59 -> 00 and carry to minutes on the same edge.
  - Minutes wrap 59 -> 00 and carry to hours on the same edge.
  - Hours wrap 23 -> 00 with no further carry.
  - Inc presses are ignored.
- SET_MIN mode:
  - On entry, seconds are cleared to 00 on the transition edge.
  - Each inc press increments minutes, visible the next cycle; 59 -> 00 does NOT carry into hours.
- SET_HOUR mode:
  - Each inc press increments hours, 23 -> 00.
  - Minutes and seconds are held.
- Mode FSM:
  - A mode press advances RUN -> SET_MIN -> SET_HOUR -> RUN; encoding value 3 is unreachable and recovers to RUN.
  - On re-entering RUN the prescaler starts from 0, so the first tick occurs TICK_DIV cycles after the transition edge.
- Simultaneous mode and inc pulses in the same cycle:
  - The mode transition is taken and the inc is dropped.
  - No digit changes, apart from the seconds clear on entry to SET_MIN.
- Arithmetic:
  - All digits stay in 0-9; tens digits stay in 0-5 for seconds and minutes, 0-2 for hours.
  - No illegal BCD value is ever produced.

Decomposition:
- Shared package clock_pkg holds:
  - Mode enum constants MODE_RUN, MODE_SET_MIN, MODE_SET_HOUR.
  - Digit-limit constants: SEC_MAX and MIN_MAX = 5/9; HR_MAX = 2/3.
- One sub-module, bcd2_counter:
  - Ports: clk, reset, inc, clr, max_tens[3:0], max_ones[3:0], tens[3:0], ones[3:0], wrap.
  - wrap is combinational: inc && value == max.
  - It is a fully synchronous replacement for the edge-triggered digit-pair counter.
  - Instantiated three times.
- Debouncer logic stays inline; it is two copies of roughly 15 lines each.

Test Plan:
All scenarios use TICK_DIV = 10 and DEBOUNCE_CYCLES = 4.
1. Release reset, run 600 cycles -> tick_1hz pulses every 10 cycles; after tick 59 time = 00:00:59; after tick 60 time = 00:01:00.
2. Set 23:59 via SET_MIN/SET_HOUR, return to RUN, run 60 ticks -> 00:00:00, with the hour wrap on the same edge as the seconds and minutes wrap.
3. btn_inc high for 3 cycles in SET_MIN -> no change. Then high for 100 cycles -> minutes +1 exactly once, updated DEBOUNCE_CYCLES + 3 cycles after the raw edge.
4. From 00:59:37 in RUN:
   - First mode press -> mode = 1 and time = 00:59:00.
   - One inc press -> 00:00:00 (no hour carry).
   - Mode press -> mode = 2.
   - 25 inc presses -> hours 00 -> 23 -> 00 -> 01.
5. Force mode and inc press pulses in the same cycle from RUN -> mode = 1, minutes unchanged. Force the same from SET_HOUR -> mode = 0, hours unchanged, first tick 10 cycles later.
6. Assert reset for 1 cycle while in SET_HOUR at 14:22:00 with btn_inc mid-debounce -> next cycle 00:00:00, mode = 0, tick_1hz = 0, no stray press pulse afterwards.
